// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, the NOP encoding and the fetch FSM states.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid bit.
// A flush inserts a bubble and keeps the PC fields, and it wins over a load.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + XLEN'(4);
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, boot/run FSM, retired-fetch counter, misaligned-target flag.
// state | meaning
// BOOT  | one idle edge after reset; inputs ignored, PC and IF/ID hold
// RUN   | per edge: branch redirect+flush, else stall hold, else fetch
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic            id_valid,
  output logic [31:0]     fetch_count,
  output logic            misalign_err
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_fetch_count;
  logic            r_misalign;

  logic w_run;
  logic w_flush;
  logic w_load;

  assign w_run   = (r_state == RUN);
  assign w_flush = w_run && branch_taken;
  assign w_load  = w_run && !branch_taken && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (branch_taken) begin
            // Low bits are dropped so fetch stays word-aligned; the flag records the bad target.
            r_pc <= {branch_target[XLEN-1:2], 2'b00};
            if (branch_target[1:0] != 2'b00) r_misalign <= 1'b1;
          end else if (!stall) begin
            r_pc          <= r_pc + XLEN'(4);
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_instr (id_instr),
    .o_pc    (id_pc),
    .o_pc4   (id_pc4),
    .o_valid (id_valid)
  );

  assign imem_addr    = r_pc;
  assign fetch_count  = r_fetch_count;
  assign misalign_err = r_misalign;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues expected post-edge state,
// a negedge monitor pops and compares; directed checks use hand-computed constants.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t sbq[$];

  // reference state
  logic        m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        m_mis;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hAAAA_0001;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("sb_imem_addr", imem_addr, e.addr);
      chk("sb_id_instr", id_instr, e.instr);
      chk("sb_id_pc", id_pc, e.pc);
      chk("sb_id_pc4", id_pc4, e.pc4);
      chk("sb_id_valid", {31'd0, id_valid}, {31'd0, e.valid});
      chk("sb_fetch_count", fetch_count, e.cnt);
      chk("sb_misalign", {31'd0, misalign_err}, {31'd0, e.mis});
    end
  end

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = 32'h0000_0100;
    m_instr = 32'h0;
    m_idpc  = 32'h0;
    m_idpc4 = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 32'h0;
    m_mis   = 1'b0;
  endtask

  // Apply inputs for one edge, advance the model, queue the expected post-edge state.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (b) begin
      m_pc    = t & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_valid = 1'b0;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc    = m_idpc;
    e.pc4   = m_idpc4;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    e.mis   = m_mis;
    sbq.push_back(e);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0000_0100);
    chk({tag, "_id_instr"}, id_instr, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_id_pc4"}, id_pc4, 32'h0);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #12;
    chk_reset_values("rst");

    // release away from the edge; stall/branch during BOOT must be ignored
    @(negedge clk);
    reset = 1'b1;
    #1;
    step(1'b1, 1'b1, 32'h0000_0ABC);
    chk("boot_valid", {31'd0, id_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0);
    chk("first_instr", id_instr, 32'hAAAA_0001);
    chk("first_pc", id_pc, 32'h0000_0100);
    chk("first_pc4", id_pc4, 32'h0000_0104);
    chk("first_cnt", fetch_count, 32'd1);

    // sequential fetch then two stalls
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("seq_pc", id_pc, 32'h0000_0108);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("stall_pc", id_pc, 32'h0000_0108);
    chk("stall_cnt", fetch_count, 32'd3);
    chk("stall_addr", imem_addr, 32'h0000_010C);

    // branch to 0x20, then branch+stall together to 0x80
    step(1'b0, 1'b1, 32'h0000_0020);
    chk("br20_addr", imem_addr, 32'h0000_0020);
    step(1'b1, 1'b1, 32'h0000_0080);
    chk("brst_valid", {31'd0, id_valid}, 32'd0);
    chk("brst_instr", id_instr, 32'h0);
    chk("brst_addr", imem_addr, 32'h0000_0080);
    chk("brst_cnt", fetch_count, 32'd3);
    step(1'b0, 1'b0, 32'h0);
    chk("brst_next_pc", id_pc, 32'h0000_0080);

    // misaligned target
    step(1'b0, 1'b1, 32'h0000_0043);
    chk("mis_addr", imem_addr, 32'h0000_0040);
    chk("mis_flag", {31'd0, misalign_err}, 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values("arst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    step(1'b0, 1'b0, 32'h0);
    chk("reboot_valid", {31'd0, id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("reboot_pc", id_pc, 32'h0000_0100);
    chk("reboot_cnt", fetch_count, 32'd1);
    step(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the CPU datapath. It sits directly upstream of the main control unit.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned instruction into an IF/ID pipeline register that the control unit and register file consume.
- Supports stall, branch redirect with flush, a boot cycle after reset, a retired-fetch counter and a sticky misaligned-target flag.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- XLEN, 32, datapath width (only 32 is supported).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_addr  out  XLEN  instruction-memory address; combinationally equal to the PC register.
- imem_rdata  in  XLEN  instruction word; combinational read, valid in the same cycle as imem_addr.
- stall  in  1  hold the PC and IF/ID contents.
- branch_taken  in  1  redirect fetch to branch_target and flush IF/ID.
- branch_target  in  XLEN  redirect address.
- id_instr  out  XLEN  registered instruction for decode.
- id_pc  out  XLEN  PC of id_instr.
- id_pc4  out  XLEN  id_pc + 4.
- id_valid  out  1  id_instr holds a real instruction, not a bubble.
- fetch_count  out  32  number of valid IF/ID loads since reset.
- misalign_err  out  1  sticky flag: a redirect target had nonzero bits [1:0].

## Operation
- FSM has two states: BOOT and RUN.
  - Reset forces BOOT.
  - BOOT lasts exactly one edge after reset deasserts, then moves to RUN unconditionally.
  - In BOOT, stall and branch_taken are ignored, the PC holds, and IF/ID holds its bubble.
- In RUN, exactly one action fires per edge, in priority order:
  1. **branch_taken = 1:** pc <= {branch_target[31:2], 2'b00}. IF/ID is flushed: id_instr <= NOP_INSTR, id_valid <= 0, id_pc and id_pc4 hold. If branch_target[1:0] != 0, misalign_err <= 1. The fetch counter does not increment.
  2. **stall = 1:** the PC, all IF/ID fields and fetch_count hold.
  3. **Otherwise:**
     - id_instr <= imem_rdata; id_pc <= pc; id_pc4 <= pc + 4; id_valid <= 1.
     - pc <= pc + 4.
     - fetch_count <= fetch_count + 1.
- Branch beats stall when both are asserted.
- Arithmetic is modulo 2^32:
  - pc + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- misalign_err clears only on reset.
- Reset asserted mid-operation immediately (asynchronously) returns every register to its reset value, regardless of stall or branch.

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - id_instr = NOP_INSTR (32'h0000_0000); id_pc = 0; id_pc4 = 0; id_valid = 0.
  - fetch_count = 0; misalign_err = 0; state = BOOT.
- Edge sequence after reset deasserts:
  - Edge 1: BOOT -> RUN, no load.
  - Edge 2: first valid IF/ID load, with id_pc = RESET_PC.
  - Edge 3: second load, with id_pc = RESET_PC + 4.
- Fetch latency: an instruction at address A appears on id_instr one edge after imem_addr = A with stall low.
- Redirect:
  - Edge N (branch_taken high): bubble into IF/ID, pc <= target.
  - Edge N+1 (no stall): instruction at target loads.
  - Branch penalty from decode is one bubble.
- imem_addr changes only on clock edges or on asynchronous reset. It has no combinational path from stall or branch_taken.

## Structure
- Shared package cpu_pkg contains:
  - XLEN
  - NOP_INSTR = 32'h0000_0000
  - the fetch FSM enum {BOOT, RUN}
- One sub-module, if_id_reg, holds id_instr, id_pc, id_pc4 and id_valid.
  - Inputs: load, flush, d_instr, d_pc.
  - It computes pc4 internally.
  - flush has priority over load.
- fetch_stage contains the PC register, FSM, counter and misalign logic, and instantiates if_id_reg.

## Test plan
- **Reset/boot:** RESET_PC = 32'h100, memory word at 32'h100 = 32'hAAAA_0001.
  - Release reset: first edge gives id_valid = 0 and imem_addr = 32'h100.
  - Second edge gives id_instr = 32'hAAAA_0001, id_pc = 32'h100, id_pc4 = 32'h104, fetch_count = 1.
- **Sequential fetch and stall:** run 3 edges, then stall for 2 edges.
  - id_pc steps 0, 4, 8, then holds at 8 for 2 edges.
  - fetch_count holds at 3; imem_addr holds at 12.
- **Branch with simultaneous stall:** with pc = 32'h20, assert branch_taken (target 32'h80) and stall together.
  - Next edge: id_valid = 0, id_instr = 0, imem_addr = 32'h80, fetch_count unchanged.
  - Following edge: id_pc = 32'h80.
- **Misaligned target 32'h0000_0043:** pc becomes 32'h40 and misalign_err = 1.
  - misalign_err stays 1 through 10 further fetches.
  - misalign_err clears only on reset.
- **Wrap-around:** force the PC to 32'hFFFF_FFFC via branch, then fetch.
  - Result: id_pc = 32'hFFFF_FFFC, id_pc4 = 0, next imem_addr = 0.
- **Asynchronous reset mid-run:** assert reset between edges during streaming.
  - All outputs reach reset values with no clock edge.
  - BOOT is re-entered after release.
